// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_reader_pkg: shared constants and state encoding for the SPI flash reader
package spi_flash_reader_pkg;
  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  localparam int         SPI_DUMMY_CYCLES  = 8;
  localparam int         ADDR_W            = 24;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL} state_t;
endpackage

// File: rtl/spi_flash_reader_clk_gen.sv
// spi_clk_gen: SCK divider with rise/fall strobes; ports clk, reset_b, en (run), hold (freeze while SCK low), sck, rise, fall
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic en,
  input  logic hold,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);
  logic [DW-1:0] cnt_q, cnt_d;
  logic sck_q, sck_d, freeze, tick;
  // hold only takes effect once SCK is low, so a pending high phase always completes
  always_comb begin
    freeze = hold && !sck_q;
    tick   = en && !freeze && cnt_q == TERM;
    rise   = tick && !sck_q;
    fall   = tick && sck_q;
    cnt_d  = !en ? '0 : freeze ? cnt_q : tick ? '0 : cnt_q + DW'(1);
    sck_d  = en && (sck_q ^ tick);
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end
  assign sck = sck_q;
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: streams a byte range out of a mode-0 SPI flash; start/addr/len request, busy/done status, data/data_valid/data_ready byte stream, spi_* pins; SPI_FAST_READ_EN selects 0x0B with dummy cycles
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);
`ifdef SPI_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [7:0] CMD_BYTE = FAST ? SPI_CMD_FAST_READ : SPI_CMD_READ;
  localparam int WW = $clog2(2 * CLK_DIV + 1);
  localparam logic [WW-1:0] GAP       = WW'(2 * CLK_DIV);
  localparam logic [WW-1:0] DESEL_END = WW'(CLK_DIV - 1);
  state_t state_q, state_d;
  logic [4:0] bit_q, bit_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0] tx_q, tx_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] data_q, data_d;
  logic dv_q, dv_d, mosi_q, mosi_d, cs_q, busy_q, done_q, done_d;
  logic sck, rise, fall, clk_en, hold, accept, go, last_bit, byte_done;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk(clk), .reset_b(reset_b), .en(clk_en), .hold(hold),
    .sck(sck), .rise(rise), .fall(fall)
  );
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_CMD;
      S_CMD:   if (rise && last_bit) state_d = S_ADDR;
      S_ADDR:  if (rise && last_bit) state_d = FAST ? S_DUMMY : S_DATA;
      S_DUMMY: if (rise && last_bit) state_d = S_DATA;
      S_DATA:  if (rem_q == '0 && !sck && !dv_q) state_d = S_DESEL;
      S_DESEL: if (wait_q == DESEL_END) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // wait_q doubles as the CS-high guard: a start is only taken once CS has been high 2*CLK_DIV clocks
  always_comb begin
    accept    = state_q == S_IDLE && start && wait_q == GAP;
    go        = accept && len != '0;
    clk_en    = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
    last_bit  = state_q == S_ADDR ? bit_q == 5'd31 :
                state_q == S_DUMMY ? bit_q == 5'(SPI_DUMMY_CYCLES - 1) : bit_q[2:0] == 3'd7;
    hold      = state_q == S_DATA && (rem_q == '0 || (dv_q && bit_q[2:0] == 3'd7));
    byte_done = rise && state_q == S_DATA && bit_q[2:0] == 3'd7;
    done_d    = (accept && len == '0) || (state_q == S_DESEL && wait_q == DESEL_END);
  end
  always_comb begin
    tx_d   = go ? {CMD_BYTE[6:0], addr, 1'b0} : fall ? {tx_q[30:0], 1'b0} : tx_q;
    mosi_d = go ? CMD_BYTE[7] : fall ? tx_q[31] : mosi_q;
    bit_d  = go ? '0 : rise ? ((last_bit && state_q != S_CMD) ? '0 : bit_q + 5'd1) : bit_q;
    rx_d   = (rise && state_q == S_DATA) ? {rx_q[5:0], spi_miso} : rx_q;
    data_d = byte_done ? {rx_q, spi_miso} : data_q;
    dv_d   = byte_done || (dv_q && !data_ready);
    rem_d  = go ? len : byte_done ? rem_q - LEN_W'(1) : rem_q;
    wait_d = state_d != state_q ? '0 : wait_q == GAP ? wait_q : wait_q + WW'(1);
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_q   <= '0;
      mosi_q <= 1'b0;
      bit_q  <= '0;
      rx_q   <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      rem_q  <= '0;
      wait_q <= '0;
      cs_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      mosi_q <= mosi_d;
      bit_q  <= bit_d;
      rx_q   <= rx_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      rem_q  <= rem_d;
      wait_q <= wait_d;
      cs_q   <= state_d == S_IDLE;
      busy_q <= state_d != S_IDLE;
      done_q <= done_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign spi_sck    = sck;
  assign spi_cs_n   = cs_q;
  assign spi_mosi   = mosi_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: randomized bench with a behavioural flash and stream model
module tb_spi_flash_reader;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int HDR = 40;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int HDR = 32;
`endif
  logic clk = 1'b0, reset_b = 1'b0, start = 1'b0, data_ready = 1'b0, spi_miso = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic busy, done, data_valid, spi_sck, spi_cs_n, spi_mosi;
  logic [7:0] data;
  always #5 clk = ~clk;
  spi_flash_reader dut (
    .clk(clk), .reset_b(reset_b), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0] mem [int];
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] h;
    h = a[7:0] * 8'd37 ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
    return mem.exists(int'(a)) ? mem[int'(a)] : h;
  endfunction
  int total_rises = 0, frame_base = 0, dummy_err = 0;
  logic [31:0] hdr = '0;
  always @(negedge spi_cs_n) frame_base = total_rises;
  always @(posedge spi_sck) begin
    int idx;
    idx = total_rises - frame_base;
    if (idx < 32) hdr = {hdr[30:0], spi_mosi};
    else if (idx < HDR && spi_mosi) dummy_err++;
    total_rises++;
  end
  always @(negedge spi_sck) begin
    int n;
    logic [7:0] b;
    n = total_rises - frame_base - HDR;
    if (n >= 0) begin
      b = mem_byte(hdr[23:0] + 24'(n / 8));
      spi_miso = b[7 - n % 8];
    end
  end
  int rdy_mode = 0, done_cnt = 0, cs_low_cyc = 0, stab_err = 0;
  logic [7:0] got_all [$];
  logic pend = 1'b0;
  logic [7:0] pend_data = '0;
  always @(negedge clk) begin
    logic r;
    r = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    if (done) done_cnt++;
    if (!spi_cs_n) cs_low_cyc++;
    if (pend && (!data_valid || data !== pend_data)) stab_err++;
    if (data_valid && r) got_all.push_back(data);
    pend = reset_b && data_valid && !r;
    pend_data = data;
    data_ready = r;
  end
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_xfer(input logic [23:0] a, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    addr = a;
    len = n;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic finish_xfer(input logic [23:0] a, input int n, input int r0, input int d0, input int g0);
    int cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", 32'(cyc < 20000), 1);
    wait_cycles(3);
    chk("header", hdr, {EXP_CMD, a});
    chk("sck_rises", total_rises - r0, HDR + 8 * n);
    chk("nbytes", got_all.size() - g0, n);
    for (int i = 0; i < n; i++)
      if (g0 + i < got_all.size()) chk("byte", {24'h0, got_all[g0 + i]}, {24'h0, mem_byte(a + 24'(i))});
    chk("done_pulses", done_cnt - d0, 1);
    chk("cs_idle", {31'h0, spi_cs_n}, 1);
    chk("busy_idle", {31'h0, busy}, 0);
    chk("dummy_mosi", dummy_err, 0);
    chk("stable", stab_err, 0);
  endtask
  task automatic xfer(input logic [23:0] a, input int n, input int mode);
    int r0, d0, g0;
    rdy_mode = mode;
    r0 = total_rises;
    d0 = done_cnt;
    g0 = got_all.size();
    start_xfer(a, 16'(n));
    finish_xfer(a, n, r0, d0, g0);
    wait_cycles(10);
  endtask
  initial begin
    int r0, r1, d0, g0, c0, cyc;
    logic [23:0] a;
    mem[32'h012345] = 8'hA5;
    mem[32'h012346] = 8'h5A;
    mem[32'h012347] = 8'h3C;
    mem[32'h012348] = 8'hC3;
    wait_cycles(3);
    reset_b = 1'b1;
    wait_cycles(100);
    chk("rst_cs", {31'h0, spi_cs_n}, 1);
    chk("rst_sck", {31'h0, spi_sck}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_dv", {31'h0, data_valid}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_data", {24'h0, data}, 0);
    chk("rst_mosi", {31'h0, spi_mosi}, 0);
    xfer(24'h012345, 4, 0);
    a = 24'($urandom);
    rdy_mode = 2;
    r0 = total_rises;
    d0 = done_cnt;
    g0 = got_all.size();
    start_xfer(a, 16'd3);
    cyc = 0;
    while (!data_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("dv_timeout", 32'(cyc < 2000), 1);
    r1 = total_rises;
    wait_cycles(50);
    chk("hold_rises", total_rises - r1, 7);
    chk("hold_sck", {31'h0, spi_sck}, 0);
    chk("hold_dv", {31'h0, data_valid}, 1);
    chk("hold_data", {24'h0, data}, {24'h0, mem_byte(a)});
    rdy_mode = 0;
    finish_xfer(a, 3, r0, d0, g0);
    wait_cycles(10);
    r0 = total_rises;
    d0 = done_cnt;
    c0 = cs_low_cyc;
    @(negedge clk);
    start = 1'b1;
    len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", {31'h0, done}, 1);
    chk("zero_busy", {31'h0, busy}, 0);
    @(negedge clk);
    chk("zero_done_clr", {31'h0, done}, 0);
    wait_cycles(5);
    chk("zero_rises", total_rises - r0, 0);
    chk("zero_cs", cs_low_cyc - c0, 0);
    chk("zero_pulses", done_cnt - d0, 1);
    r0 = total_rises;
    d0 = done_cnt;
    start_xfer(24'($urandom), 16'd4);
    cyc = 0;
    while (total_rises - r0 < 12 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("addr_timeout", 32'(cyc < 2000), 1);
    #2 reset_b = 1'b0;
    #1;
    chk("abort_cs", {31'h0, spi_cs_n}, 1);
    chk("abort_sck", {31'h0, spi_sck}, 0);
    chk("abort_busy", {31'h0, busy}, 0);
    wait_cycles(3);
    reset_b = 1'b1;
    wait_cycles(30);
    chk("abort_no_done", done_cnt - d0, 0);
    xfer(24'($urandom), 1, 0);
    xfer(24'h000000, 1, 0);
    xfer(24'hFFFFFE, 4, 1);
    for (int i = 0; i < 6; i++) xfer(24'($urandom), $urandom_range(1, 6), $urandom_range(0, 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
